// File: rtl/pin_bus_pkg.sv
// pin_bus_pkg -- shared types for the pin bus bridge.
//   state_e     : bridge FSM states
//   PH_*        : pin_phase encodings driven on the pin bus
//   beat_cw()   : width of a beat counter able to index 'beats' slices
package pin_bus_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_WDATA,
      S_TURN,
      S_RDATA,
      S_DONE
   } state_e;

   localparam logic [1:0] PH_IDLE  = 2'd0;  // idle or bus turnaround
   localparam logic [1:0] PH_ADDR  = 2'd1;
   localparam logic [1:0] PH_WDATA = 2'd2;
   localparam logic [1:0] PH_RDATA = 2'd3;

   function automatic int beat_cw(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/pin_bus_bridge_counter.sv
// pin_beat_counter -- beat index within one bus phase.
//   clk_i/rst_i : clock, synchronous active-high reset
//   clr_i       : return to beat 0 (phase change); wins over en_i
//   en_i        : advance one beat; saturates at tc_i, never wraps
//   tc_i        : index of the final beat of the current phase
//   cnt_o       : current beat index
//   cnt_nxt_o   : index the counter takes at the next edge
//   last_o      : current beat is the final one
module pin_beat_counter #(
   parameter int CW = 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clr_i,
   input  logic          en_i,
   input  logic [CW-1:0] tc_i,
   output logic [CW-1:0] cnt_o,
   output logic [CW-1:0] cnt_nxt_o,
   output logic          last_o
);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && (cnt_q != tc_i))
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o     = cnt_q;
   assign cnt_nxt_o = cnt_d;
   assign last_o    = (cnt_q == tc_i);

endmodule

// File: rtl/pin_bus_bridge.sv
// pin_bus_bridge -- serialises CPU read/write requests onto a narrow
// multiplexed pin bus (address beats, then write-data beats or a
// turnaround followed by read-data beats), all LSB slice first.
//   clk, rst          : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata : request, sampled only in IDLE
//   cpu_rdata, cpu_ack    : read result, one-cycle completion pulse
//   pin_out/pin_oe        : beat driven to the pins and its enable
//   pin_in                : read-data beat from the pins
//   pin_wait              : external stall
//   pin_phase             : beat type (PH_* in pin_bus_pkg)
// Build option: define PIN_BUS_WAIT_EN to let pin_wait stall the
// ADDR/WDATA/RDATA phases; otherwise pin_wait has no effect.
module pin_bus_bridge
   import pin_bus_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int PW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ack,
   output logic [PW-1:0] pin_out,
   output logic [PW-1:0] pin_oe,
   input  logic [PW-1:0] pin_in,
   input  logic          pin_wait,
   output logic [1:0]    pin_phase
);

   localparam int AWB  = AW / PW;
   localparam int DWB  = DW / PW;
   localparam int MAXB = (AWB > DWB) ? AWB : DWB;
   localparam int CW   = beat_cw(MAXB);

`ifdef PIN_BUS_WAIT_EN
   localparam bit WAIT_EN = 1'b1;
`else
   localparam bit WAIT_EN = 1'b0;
`endif

   state_e        state_q, state_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;

   logic          ack_q;
   logic [PW-1:0] pout_q, pout_d;
   logic [PW-1:0] poe_q, poe_d;
   logic [1:0]    phase_q, phase_d;

   logic          cnt_clr, cnt_en, cnt_last, frozen;
   logic [CW-1:0] cnt, cnt_nxt, cnt_tc;

   assign cnt_tc = (state_q == S_ADDR) ? CW'(AWB - 1) : CW'(DWB - 1);

   pin_beat_counter #(.CW(CW)) u_cnt (
      .clk_i     (clk),
      .rst_i     (rst),
      .clr_i     (cnt_clr),
      .en_i      (cnt_en),
      .tc_i      (cnt_tc),
      .cnt_o     (cnt),
      .cnt_nxt_o (cnt_nxt),
      .last_o    (cnt_last)
   );

   // A stall only applies while beats are moving on the pins.
   assign frozen = WAIT_EN & pin_wait &
                   ((state_q == S_ADDR) || (state_q == S_WDATA) || (state_q == S_RDATA));

   // Next-state, request latch and read-data capture.
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cpu_req) begin
               we_d    = cpu_we;
               addr_d  = cpu_addr;
               wdata_d = cpu_wdata;
               state_d = S_ADDR;
               cnt_clr = 1'b1;
            end
         end
         S_ADDR: begin
            if (!frozen) begin
               if (cnt_last) begin
                  state_d = we_q ? S_WDATA : S_TURN;
                  cnt_clr = 1'b1;
               end else begin
                  cnt_en = 1'b1;
               end
            end
         end
         S_WDATA: begin
            if (!frozen) begin
               if (cnt_last) begin
                  state_d = S_DONE;
                  cnt_clr = 1'b1;
               end else begin
                  cnt_en = 1'b1;
               end
            end
         end
         S_TURN: begin
            state_d = S_RDATA;
            cnt_clr = 1'b1;
         end
         S_RDATA: begin
            if (!frozen) begin
               rdata_d[int'(cnt)*PW +: PW] = pin_in;
               if (cnt_last) begin
                  state_d = S_DONE;
                  cnt_clr = 1'b1;
               end else begin
                  cnt_en = 1'b1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state and next beat index so the
   // pin registers present each beat in the same cycle the FSM is in it.
   always_comb begin
      pout_d  = '0;
      poe_d   = '0;
      phase_d = PH_IDLE;
      case (state_d)
         S_ADDR: begin
            pout_d  = addr_d[int'(cnt_nxt)*PW +: PW];
            poe_d   = '1;
            phase_d = PH_ADDR;
         end
         S_WDATA: begin
            pout_d  = wdata_d[int'(cnt_nxt)*PW +: PW];
            poe_d   = '1;
            phase_d = PH_WDATA;
         end
         S_RDATA: phase_d = PH_RDATA;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ack_q   <= 1'b0;
         pout_q  <= '0;
         poe_q   <= '0;
         phase_q <= PH_IDLE;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ack_q   <= (state_d == S_DONE);
         pout_q  <= pout_d;
         poe_q   <= poe_d;
         phase_q <= phase_d;
      end
   end

   assign cpu_rdata = rdata_q;
   assign cpu_ack   = ack_q;
   assign pin_out   = pout_q;
   assign pin_oe    = poe_q;
   assign pin_phase = phase_q;

endmodule

// File: tb/tb_pin_bus_bridge.sv
// tb_pin_bus_bridge -- directed bench for pin_bus_bridge: a default-size
// instance (32/32/8) and a narrow one (16/8/4). Inputs change and outputs
// are sampled on the falling edge; "k" counts cycles after acceptance.
module tb_pin_bus_bridge;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // default instance
   logic        req = 1'b0, we = 1'b0;
   logic [31:0] addr = '0, wdata = '0, rdata;
   logic        ack;
   logic [7:0]  pout, poe, pin = '0;
   logic        pwait = 1'b0;
   logic [1:0]  phase;

   // narrow instance
   logic        req_b = 1'b0, we_b = 1'b0;
   logic [15:0] addr_b = '0;
   logic [7:0]  wdata_b = '0, rdata_b;
   logic        ack_b;
   logic [3:0]  pout_b, poe_b, pin_b = '0;
   logic        pwait_b = 1'b0;
   logic [1:0]  phase_b;

   pin_bus_bridge u_dut (
      .clk(clk), .rst(rst), .cpu_req(req), .cpu_we(we), .cpu_addr(addr),
      .cpu_wdata(wdata), .cpu_rdata(rdata), .cpu_ack(ack), .pin_out(pout),
      .pin_oe(poe), .pin_in(pin), .pin_wait(pwait), .pin_phase(phase)
   );

   pin_bus_bridge #(.AW(16), .DW(8), .PW(4)) u_dut_b (
      .clk(clk), .rst(rst), .cpu_req(req_b), .cpu_we(we_b), .cpu_addr(addr_b),
      .cpu_wdata(wdata_b), .cpu_rdata(rdata_b), .cpu_ack(ack_b), .pin_out(pout_b),
      .pin_oe(poe_b), .pin_in(pin_b), .pin_wait(pwait_b), .pin_phase(phase_b)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask

   // write 0x12345678 / 0xCAFEF00D, k = 1..10
   logic [7:0] wr_out [10] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'h00, 8'h00};
   logic [1:0] wr_ph  [10] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
   logic [7:0] wr_oe  [10] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
   // read, k = 1..11
   logic [1:0] rd_ph  [11] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
   logic [7:0] rd_oe  [11] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
   logic [7:0] rd_in  [11] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 8'h00};
   // stalled read, k = 1..13
   logic [7:0] wt_in  [13] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hBE, 8'hBE,
                               8'hAD, 8'hDE, 8'h00, 8'h00};
   // narrow write 0xA5C3 / 0x7E, k = 1..8
   logic [3:0] nb_out [8] = '{4'h3, 4'hC, 4'h5, 4'hA, 4'hE, 4'h7, 4'h0, 4'h0};
   logic [1:0] nb_ph  [8] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0};

`ifdef PIN_BUS_WAIT_EN
   localparam int          WT_ACK  = 12;
   localparam logic [31:0] WT_DATA = 32'hDEADBEEF;
`else
   localparam int          WT_ACK  = 10;
   localparam logic [31:0] WT_DATA = 32'hBEBEBEEF;
`endif

   task automatic run_write(input string pfx);
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 32'h12345678; wdata = 32'hCAFEF00D;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         chk($sformatf("%s_out[%0d]", pfx, k), 32'(pout), 32'(wr_out[k-1]));
         chk($sformatf("%s_ph[%0d]", pfx, k), 32'(phase), 32'(wr_ph[k-1]));
         chk($sformatf("%s_oe[%0d]", pfx, k), 32'(poe), 32'(wr_oe[k-1]));
         chk($sformatf("%s_ack[%0d]", pfx, k), 32'(ack), 32'(k == 9));
         req = 1'b0;
      end
   endtask

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_out", 32'(pout), 32'd0);
      chk("rst_oe", 32'(poe), 32'd0);
      chk("rst_ph", 32'(phase), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_b_out", 32'(pout_b), 32'd0);
      rst = 1'b0;

      // write on default widths
      run_write("wr");

      // read on default widths
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 32'h00000010;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         chk($sformatf("rd_ph[%0d]", k), 32'(phase), 32'(rd_ph[k-1]));
         chk($sformatf("rd_oe[%0d]", k), 32'(poe), 32'(rd_oe[k-1]));
         chk($sformatf("rd_ack[%0d]", k), 32'(ack), 32'(k == 10));
         if (k == 5) chk("rd_turn_out", 32'(pout), 32'd0);
         if (k >= 10) chk($sformatf("rd_data[%0d]", k), rdata, 32'hDEADBEEF);
         req = 1'b0;
         pin = rd_in[k-1];
      end

      // read with two stall cycles on the second data beat
      @(negedge clk);
      req = 1'b1; we = 1'b0;
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         chk($sformatf("wt_ack[%0d]", k), 32'(ack), 32'(k == WT_ACK));
         if (k == WT_ACK) chk("wt_data", rdata, WT_DATA);
         if (k >= 6 && k <= 9) chk($sformatf("wt_ph[%0d]", k), 32'(phase), 32'd3);
         req = 1'b0;
         pin = wt_in[k-1];
         pwait = (k == 7 || k == 8);
      end
      pwait = 1'b0;

      // reset during the third address beat of a write
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 32'h12345678; wdata = 32'hCAFEF00D;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         req = 1'b0;
         if (k == 3) begin
            chk("ab_beat3", 32'(pout), 32'h34);
            rst = 1'b1;
         end
         if (k == 4) begin
            chk("ab_out", 32'(pout), 32'd0);
            chk("ab_oe", 32'(poe), 32'd0);
            chk("ab_ph", 32'(phase), 32'd0);
            chk("ab_rdata", rdata, 32'd0);
            rst = 1'b0;
         end
         if (k >= 4) chk($sformatf("ab_ack[%0d]", k), 32'(ack), 32'd0);
      end
      run_write("ab_wr");

      // reset dominates a request in the same cycle
      @(negedge clk);
      rst = 1'b1; req = 1'b1; we = 1'b1;
      @(negedge clk);
      rst = 1'b0; req = 1'b0;
      chk("rd_dom_ph", 32'(phase), 32'd0);
      @(negedge clk);
      chk("rd_dom_ph2", 32'(phase), 32'd0);

      // back-to-back writes with cpu_req held high
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 32'h12345678; wdata = 32'hCAFEF00D;
      for (int k = 1; k <= 21; k++) begin
         @(negedge clk);
         chk($sformatf("bb_ack[%0d]", k), 32'(ack), 32'(k == 9 || k == 19));
         if (k == 10) chk("bb_gap_ph", 32'(phase), 32'd0);
         if (k == 11) begin
            chk("bb_ph2", 32'(phase), 32'd1);
            chk("bb_out2", 32'(pout), 32'h78);
            req = 1'b0;
         end
      end

      // narrow instance write
      @(negedge clk);
      req_b = 1'b1; we_b = 1'b1; addr_b = 16'hA5C3; wdata_b = 8'h7E;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         chk($sformatf("nb_out[%0d]", k), 32'(pout_b), 32'(nb_out[k-1]));
         chk($sformatf("nb_ph[%0d]", k), 32'(phase_b), 32'(nb_ph[k-1]));
         chk($sformatf("nb_ack[%0d]", k), 32'(ack_b), 32'(k == 7));
         req_b = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
